// File: rtl/spio_pkt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spio_pkt_pkg
// Brief    : Shared packet definitions for the SpiNNaker link packet path:
//            packet width, field positions and a port-index width helper.
// Revision : 1.0 - initial release
// ============================================================================
package spio_pkt_pkg;

    // Full packet: {payload[71:40], key[39:8], header[7:0]}
    localparam int PKT_BITS = 72;

    // Field positions inside a packet
    localparam int HDR_LSB  = 0;
    localparam int HDR_BITS = 8;
    localparam int KEY_LSB  = 8;
    localparam int KEY_BITS = 32;
    localparam int PLD_LSB  = 40;
    localparam int PLD_BITS = 32;

    // Bits needed to index n ports (never less than one bit)
    function automatic int idx_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spio_rr_priority_pick.sv
`default_nettype none
// ============================================================================
// Module   : spio_rr_priority_pick
// Brief    : Combinational round-robin pick. Rotates the request vector so
//            the port after the last winner sits at bit 0, priority-encodes
//            the lowest set bit and rotates the result back.
// Revision : 1.0 - initial release
// ============================================================================
module spio_rr_priority_pick #(
    parameter int NUM_REQ  = 4,
    parameter int IDX_BITS = 2
) (
    input  logic [NUM_REQ-1:0]  i_req,
    input  logic [IDX_BITS-1:0] i_last,
    output logic [NUM_REQ-1:0]  o_gnt,
    output logic [IDX_BITS-1:0] o_gnt_idx,
    output logic                o_any
);

    // One extra bit so that last+1 and base+offset never overflow
    localparam logic [IDX_BITS:0] c_NUM = (IDX_BITS+1)'(NUM_REQ);

    logic [IDX_BITS:0]    w_base;
    logic [IDX_BITS:0]    w_off;
    logic [IDX_BITS:0]    w_sum;
    logic [2*NUM_REQ-1:0] w_req2;
    logic [NUM_REQ-1:0]   w_rot;
    logic [2*NUM_REQ-1:0] w_gnt2;

    // Rotate, priority-encode from the rotated bit 0 upward, rotate back
    always_comb begin
        w_base = {1'b0, i_last} + (IDX_BITS+1)'(1);
        if (w_base >= c_NUM) begin
            w_base = '0;
        end

        // Doubling the vector turns the wrap-around into a plain shift
        w_req2 = {i_req, i_req};
        w_rot  = NUM_REQ'(w_req2 >> w_base);

        // Scan downward so the lowest rotated index is the final winner
        w_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = (IDX_BITS+1)'(k);
            end
        end

        w_sum = w_base + w_off;
        if (w_sum >= c_NUM) begin
            w_sum = w_sum - c_NUM;
        end

        o_any     = |i_req;
        o_gnt_idx = w_sum[IDX_BITS-1:0];

        w_gnt2 = {{(2*NUM_REQ-1){1'b0}}, 1'b1} << w_sum;
        o_gnt  = o_any ? (w_gnt2[NUM_REQ-1:0] | w_gnt2[2*NUM_REQ-1:NUM_REQ])
                       : '0;
    end

endmodule
`default_nettype wire

// File: rtl/spio_spinnaker_link_pkt_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spio_spinnaker_link_pkt_arbiter
// Brief    : Round-robin merge of several 72-bit link packet streams into a
//            single registered output slot. One whole packet is granted per
//            handshake; a per-port enable mask removes links from service.
// Revision : 1.0 - initial release
// ============================================================================
module spio_spinnaker_link_pkt_arbiter
    import spio_pkt_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int PKT_BITS  = spio_pkt_pkg::PKT_BITS,
    parameter int IDX_BITS  = idx_bits(NUM_PORTS)
) (
    input  logic                          CLK_IN,
    input  logic                          RESET_IN,
    input  logic [NUM_PORTS-1:0]          PORT_EN_IN,
    input  logic [NUM_PORTS*PKT_BITS-1:0] PKT_DATA_IN,
    input  logic [NUM_PORTS-1:0]          PKT_VLD_IN,
    output logic [NUM_PORTS-1:0]          PKT_RDY_OUT,
    output logic [PKT_BITS-1:0]           PKT_DATA_OUT,
    output logic                          PKT_VLD_OUT,
    input  logic                          PKT_RDY_IN,
    output logic [IDX_BITS-1:0]           LAST_GNT_OUT
);

    // Output slot and round-robin pointer
    logic [PKT_BITS-1:0]  r_data;
    logic                 r_vld;
    logic [IDX_BITS-1:0]  r_last;

    logic                 w_free;
    logic                 w_load;
    logic [NUM_PORTS-1:0] w_req;
    logic [NUM_PORTS-1:0] w_gnt;
    logic [IDX_BITS-1:0]  w_gnt_idx;
    logic                 w_any;
    logic [PKT_BITS-1:0]  w_sel;

    // Slot can accept when empty or being drained this cycle
    assign w_free = !r_vld || PKT_RDY_IN;

    // Only enabled ports with a packet on offer compete
    assign w_req  = PKT_VLD_IN & PORT_EN_IN;

    spio_rr_priority_pick #(
        .NUM_REQ  (NUM_PORTS),
        .IDX_BITS (IDX_BITS)
    ) u_pick (
        .i_req     (w_req),
        .i_last    (r_last),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_any     (w_any)
    );

    // Ready is held off during reset so nothing is accepted and then lost
    assign PKT_RDY_OUT = (w_free && !RESET_IN) ? w_gnt : '0;
    assign w_load      = w_free && w_any;

    // AND-OR select of the granted port's packet (grant is one-hot)
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_gnt[i]) begin
                w_sel = w_sel | PKT_DATA_IN[i*PKT_BITS +: PKT_BITS];
            end
        end
    end

    // Slot and pointer update; pointer only moves on an actual grant
    always_ff @(posedge CLK_IN) begin
        if (RESET_IN) begin
            r_vld  <= 1'b0;
            r_data <= '0;
            r_last <= IDX_BITS'(NUM_PORTS - 1);
        end else if (w_free) begin
            if (w_load) begin
                r_vld  <= 1'b1;
                r_data <= w_sel;
                r_last <= w_gnt_idx;
            end else begin
                r_vld  <= 1'b0;
            end
        end
    end

    assign PKT_DATA_OUT = r_data;
    assign PKT_VLD_OUT  = r_vld;
    assign LAST_GNT_OUT = r_last;

endmodule
`default_nettype wire

// File: tb/tb_spio_spinnaker_link_pkt_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spio_spinnaker_link_pkt_arbiter
// Brief    : Directed and randomized bench for the link packet arbiter with a
//            slot/pointer reference model and a per-port ordering scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spio_spinnaker_link_pkt_arbiter;
    import spio_pkt_pkg::*;

    localparam int NP = 4;
    localparam int PB = PKT_BITS;
    localparam int IW = 2;

    logic             tb_clk = 1'b0;
    logic             tb_rst;
    logic [NP-1:0]    port_en;
    logic [NP*PB-1:0] pkt_data_in;
    logic [NP-1:0]    pkt_vld_in;
    logic [NP-1:0]    pkt_rdy_out;
    logic [PB-1:0]    pkt_data_out;
    logic             pkt_vld_out;
    logic             pkt_rdy_in;
    logic [IW-1:0]    last_gnt;

    always #5 tb_clk = ~tb_clk;

    spio_spinnaker_link_pkt_arbiter #(
        .NUM_PORTS (NP),
        .PKT_BITS  (PB)
    ) dut (
        .CLK_IN       (tb_clk),
        .RESET_IN     (tb_rst),
        .PORT_EN_IN   (port_en),
        .PKT_DATA_IN  (pkt_data_in),
        .PKT_VLD_IN   (pkt_vld_in),
        .PKT_RDY_OUT  (pkt_rdy_out),
        .PKT_DATA_OUT (pkt_data_out),
        .PKT_VLD_OUT  (pkt_vld_out),
        .PKT_RDY_IN   (pkt_rdy_in),
        .LAST_GNT_OUT (last_gnt)
    );

    int errors = 0;
    int checks = 0;

    // Upstream sources: each holds its packet until granted
    logic [PB-1:0] src_data [NP];
    bit            src_vld  [NP];
    int            seq      [NP];
    bit            keep;      // directed: source re-offers after a grant
    bit            rnd;       // random phase active
    bit            gen_on;    // random sources may create new packets

    // Reference model of slot and pointer
    bit            m_vld;
    logic [PB-1:0] m_data;
    int            m_last;

    logic [PB-1:0] sb [NP][$];
    int            wait_cnt [NP];

    task automatic check(input string tag, input logic [PB-1:0] got, input logic [PB-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [PB-1:0] mk(input int port, input logic [31:0] key, input logic [31:0] pld);
        logic [PB-1:0] p;
        p = '0;
        p[HDR_LSB +: HDR_BITS] = 8'(port);
        p[KEY_LSB +: KEY_BITS] = key;
        p[PLD_LSB +: PLD_BITS] = pld;
        return p;
    endfunction

    task automatic apply_inputs();
        for (int i = 0; i < NP; i++) begin
            pkt_vld_in[i]          = src_vld[i];
            pkt_data_in[i*PB +: PB] = src_data[i];
        end
    endtask

    // One clock: check ready, predict, clock, update sources, check outputs
    task automatic cycle();
        int            g;
        bit            free;
        logic [NP-1:0] exp_rdy;
        apply_inputs();
        #1;
        free = !m_vld || pkt_rdy_in;
        g = -1;
        if (!tb_rst) begin
            for (int k = 1; k <= NP; k++) begin
                int idx;
                idx = (m_last + k) % NP;
                if (g < 0 && pkt_vld_in[idx] && port_en[idx]) g = idx;
            end
        end
        exp_rdy = '0;
        if (free && g >= 0) exp_rdy[g] = 1'b1;
        check("rdy", PB'(pkt_rdy_out), PB'(exp_rdy));
        if (!free) g = -1;

        // Scoreboard: drained packet must be the oldest outstanding of its port
        if (rnd && m_vld && pkt_rdy_in && !tb_rst) begin
            int p;
            p = int'(pkt_data_out[HDR_LSB +: HDR_BITS]);
            check("sb_port_ok", PB'(p < NP), PB'(1));
            if (p < NP) begin
                check("sb_nonempty", PB'(sb[p].size() > 0), PB'(1));
                if (sb[p].size() > 0) check("sb_order", pkt_data_out, sb[p].pop_front());
            end
        end

        // Fairness: count grants to others while a port stays eligible
        for (int i = 0; i < NP; i++) begin
            if (tb_rst || !(pkt_vld_in[i] && port_en[i])) begin
                wait_cnt[i] = 0;
            end else if (g == i) begin
                if (rnd) check("fair_wait", PB'(wait_cnt[i] <= NP - 1), PB'(1));
                wait_cnt[i] = 0;
            end else if (g >= 0) begin
                wait_cnt[i]++;
            end
        end

        if (tb_rst) begin
            m_vld = 0; m_data = '0; m_last = NP - 1;
        end else if (free) begin
            if (g >= 0) begin
                m_vld = 1; m_data = src_data[g]; m_last = g;
            end else begin
                m_vld = 0;
            end
        end

        @(posedge tb_clk);
        if (g >= 0 && !tb_rst && (rnd || !keep)) src_vld[g] = 0;
        if (rnd && gen_on) begin
            for (int i = 0; i < NP; i++) begin
                if (!src_vld[i] && $urandom_range(0, 1) == 1) begin
                    seq[i]++;
                    src_data[i] = mk(i, {8'(i), 24'(seq[i])}, $urandom);
                    src_vld[i]  = 1;
                    sb[i].push_back(src_data[i]);
                end
            end
        end
        #1;
        check("vld", PB'(pkt_vld_out), PB'(m_vld));
        check("data", pkt_data_out, m_data);
        check("last", PB'(last_gnt), PB'(m_last));
    endtask

    task automatic clear_src();
        for (int i = 0; i < NP; i++) begin
            src_vld[i] = 0; src_data[i] = '0;
        end
    endtask

    initial begin
        logic [PB-1:0] held;
        int            exp4 [5];
        bit            done;
        bit            busy;

        tb_rst = 1; port_en = '1; pkt_rdy_in = 1;
        rnd = 0; gen_on = 0; keep = 0;
        m_vld = 0; m_data = '0; m_last = NP - 1;
        for (int i = 0; i < NP; i++) begin
            seq[i] = 0; wait_cnt[i] = 0;
            src_vld[i] = 1; src_data[i] = mk(i, 32'hdead_0000 + i, 32'h0);
        end

        // Reset with every input requesting: no ready, reset values
        cycle(); cycle();
        check("rst_vld", PB'(pkt_vld_out), PB'(0));
        check("rst_data", pkt_data_out, PB'(0));
        check("rst_last", PB'(last_gnt), PB'(3));
        clear_src();
        tb_rst = 0;

        // All four ports offer one packet, keys 1..4
        for (int i = 0; i < NP; i++) begin
            src_vld[i] = 1; src_data[i] = mk(i, 32'(i + 1), $urandom);
        end
        for (int k = 0; k < NP; k++) begin
            cycle();
            check("t1_key", PB'(pkt_data_out[KEY_LSB +: KEY_BITS]), PB'(k + 1));
            check("t1_last", PB'(last_gnt), PB'(k));
        end
        cycle();
        check("t1_idle", PB'(pkt_vld_out), PB'(0));

        // Ports 1 and 3 continuously valid: strict alternation
        keep = 1;
        src_vld[1] = 1; src_data[1] = mk(1, 32'h11, 32'h1);
        src_vld[3] = 1; src_data[3] = mk(3, 32'h33, 32'h3);
        for (int k = 0; k < 6; k++) begin
            cycle();
            check("t2_last", PB'(last_gnt), PB'((k % 2 == 0) ? 1 : 3));
        end

        // Back-pressure for 10 cycles with all ports requesting
        for (int i = 0; i < NP; i++) begin
            src_vld[i] = 1; src_data[i] = mk(i, 32'h100 + i, $urandom);
        end
        pkt_rdy_in = 0;
        held = m_data;
        for (int k = 0; k < 10; k++) begin
            cycle();
            check("t3_hold", pkt_data_out, held);
            check("t3_vld", PB'(pkt_vld_out), PB'(1));
        end
        pkt_rdy_in = 1;
        cycle();
        check("t3_reload", PB'(last_gnt), PB'(0));
        check("t3_reload_key", PB'(pkt_data_out[KEY_LSB +: KEY_BITS]), PB'(32'h100));

        // Port 2 disabled, then re-enabled after a grant to port 1
        tb_rst = 1; cycle(); tb_rst = 0;
        port_en = 4'b1011;
        exp4 = '{0, 1, 3, 0, 1};
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("t4_last", PB'(last_gnt), PB'(exp4[k]));
        end
        port_en = 4'b1111;
        cycle();
        check("t4_reen", PB'(last_gnt), PB'(2));

        // Reset while the slot holds key 0x55
        keep = 0; clear_src();
        cycle();
        src_vld[2] = 1; src_data[2] = mk(2, 32'h55, 32'h5555);
        pkt_rdy_in = 0;
        cycle();
        check("t5_key", PB'(pkt_data_out[KEY_LSB +: KEY_BITS]), PB'(32'h55));
        src_vld[1] = 1; src_data[1] = mk(1, 32'h61, 32'h0);
        src_vld[3] = 1; src_data[3] = mk(3, 32'h63, 32'h0);
        tb_rst = 1; cycle(); tb_rst = 0;
        check("t5_vld", PB'(pkt_vld_out), PB'(0));
        pkt_rdy_in = 1;
        cycle();
        check("t5_first", PB'(last_gnt), PB'(1));

        // Randomized traffic, enables and back-pressure
        tb_rst = 1; clear_src(); cycle(); tb_rst = 0;
        for (int i = 0; i < NP; i++) sb[i].delete();
        rnd = 1; gen_on = 1;
        for (int n = 0; n < 10000; n++) begin
            pkt_rdy_in = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) port_en = NP'($urandom);
            if ($urandom_range(0, 7) == 0) port_en = '1;
            cycle();
        end

        // Drain everything and confirm nothing was lost
        gen_on = 0; port_en = '1; pkt_rdy_in = 1; done = 0;
        for (int n = 0; n < 100 && !done; n++) begin
            busy = pkt_vld_out;
            for (int i = 0; i < NP; i++) busy = busy | src_vld[i];
            if (!busy) done = 1;
            else cycle();
        end
        check("drain_done", PB'(done), PB'(1));
        for (int i = 0; i < NP; i++) check("sb_left", PB'(sb[i].size()), PB'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
